// File: rtl/aidc_arb_pkg.sv
// Shared types and helpers for the AIDC packet arbiters.
package aidc_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Round-robin successor of ptr in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/aidc_rr_pick.sv
// Combinational rotating-priority picker: first asserted req at or after ptr, wrapping.
module aidc_rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any_req
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  always_comb begin
    int unsigned idx;
    gnt_idx = '0;
    any_req = 1'b0;
    idx     = 32'd0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[IDX_W'(idx)]) begin
        any_req = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/aidc_pkt_arbiter.sv
// Packet-level round-robin arbiter feeding the AIDC compressor; grant locked for a whole packet.
module aidc_pkt_arbiter
  import aidc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BEAT_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   data_i,
  input  logic [NUM_REQ-1:0]          last_i,
  output logic [NUM_REQ-1:0]          ready_o,
  output logic                        valid_o,
  output logic [DATA_W-1:0]           data_o,
  output logic                        last_o,
  output logic                        sop_o,
  output logic [$clog2(NUM_REQ)-1:0]  src_id_o,
  output logic [BEAT_W-1:0]           beat_cnt_o,
  input  logic                        ready_i
);

  localparam int unsigned     IDX_W   = $clog2(NUM_REQ);
  localparam logic [BEAT_W-1:0] CNT_MAX = '1;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  gnt, rr_ptr, pick_idx;
  logic              any_req, sop_r, xfer, gnt_last;
  logic [BEAT_W-1:0] cnt;

  aidc_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (valid_i),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any_req (any_req)
  );

  assign gnt_last = last_i[gnt];
  assign xfer     = (state_q == ARB_LOCK) && valid_i[gnt] && ready_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (any_req) state_d = ARB_LOCK;
      ARB_LOCK: if (xfer && gnt_last) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Zero-latency pass-through from the locked requester.
  always_comb begin
    valid_o = 1'b0;
    data_o  = '0;
    last_o  = 1'b0;
    ready_o = '0;
    if (state_q == ARB_LOCK) begin
      valid_o      = valid_i[gnt];
      data_o       = data_i[32'(gnt)*DATA_W +: DATA_W];
      last_o       = gnt_last;
      ready_o[gnt] = ready_i;
    end
  end

  assign sop_o      = sop_r & valid_o;
  assign beat_cnt_o = cnt;
  assign src_id_o   = gnt;

  // Grant, round-robin pointer and per-packet beat tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= '0;
      rr_ptr <= '0;
      sop_r  <= 1'b1;
      cnt    <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (any_req) begin
        gnt   <= pick_idx;
        sop_r <= 1'b1;
        cnt   <= '0;
      end
    end else if (xfer) begin
      if (gnt_last) begin
        rr_ptr <= IDX_W'(rr_next(32'(gnt), NUM_REQ));
        sop_r  <= 1'b1;
        cnt    <= '0;
      end else begin
        sop_r <= 1'b0;
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
